// File: rtl/bitstream_pkg.sv
// Shared types and helpers for the stochastic bitstream decoder.
// The saturation helper works one bit at a time so it stays independent of WIDTH.
package bitstream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // The accumulator only overflows to exactly 2^WIDTH, where every low bit is zero.
    // ORing the overflow bit into each low bit therefore yields all-ones.
    function automatic logic sat_bit(input logic overflow, input logic bit_in);
        return overflow | bit_in;
    endfunction

endpackage

// File: rtl/bitstream_decoder_ones_counter.sv
// Clearable, enable-gated ones accumulator (WIDTH+1 bits).
// The output count is saturated to WIDTH bits and includes the bit currently on x.
module ones_counter
    import bitstream_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             clr,
    input  logic             en,
    input  logic             x,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH:0] acc_r;
    logic [WIDTH:0] sum_s;

    assign sum_s = acc_r + {{WIDTH{1'b0}}, (x & en)};

    // Saturate the running sum bit by bit into the WIDTH-bit output.
    for (genvar i = 0; i < WIDTH; i++) begin : g_sat
        assign count[i] = sat_bit(sum_s[WIDTH], sum_s[i]);
    end

    // Accumulator register: clear has priority over counting.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            acc_r <= '0;
        end else if (clr) begin
            acc_r <= '0;
        end else if (en) begin
            acc_r <= sum_s;
        end else begin
            acc_r <= acc_r;
        end
    end

endmodule

// File: rtl/bitstream_decoder.sv
// Decodes a stochastic bitstream by counting ones over a 2^WIDTH-cycle window.
// The result is held in a register and offered through a valid/ready handshake.
module bitstream_decoder
    import bitstream_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter bit BIPOLAR = 1'b0
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             start,
    input  logic             x,
    input  logic             ready,
    output logic [WIDTH-1:0] value,
    output logic             valid,
    output logic             busy
);

    localparam logic [WIDTH-1:0] CNT_LAST = '1;
    localparam logic [WIDTH-1:0] MSB_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] cnt_r;
    logic [WIDTH-1:0] sat_s;
    logic [WIDTH-1:0] result_s;
    logic [WIDTH-1:0] value_r;
    logic             valid_r;
    logic             busy_r;
    logic             clr_s;
    logic             en_s;
    logic             load_s;

    ones_counter #(.WIDTH(WIDTH)) u_ones (
        .clk   (clk),
        .n_rst (n_rst),
        .clr   (clr_s),
        .en    (en_s),
        .x     (x),
        .count (sat_s)
    );

    // Bipolar offset of -2^(WIDTH-1) is the same as flipping the MSB.
    assign result_s = sat_s ^ (BIPOLAR ? MSB_MASK : {WIDTH{1'b0}});

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_next_s = state_r;
        clr_s        = 1'b0;
        en_s         = 1'b0;
        load_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_next_s = COUNT;
                    clr_s        = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            COUNT: begin
                en_s = 1'b1;
                if (cnt_r == CNT_LAST) begin
                    load_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = COUNT;
                end
            end
            DONE: begin
                if (ready) begin
                    if (start) begin
                        state_next_s = COUNT;
                        clr_s        = 1'b1;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = DONE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Sample counter; wraps to zero naturally on the final sample.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_r <= '0;
        end else if (clr_s) begin
            cnt_r <= '0;
        end else if (en_s) begin
            cnt_r <= cnt_r + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Output registers: flags follow the next state so they change with it.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            value_r <= '0;
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            value_r <= load_s ? result_s : value_r;
            valid_r <= (state_next_s == DONE);
            busy_r  <= (state_next_s == COUNT);
        end
    end

    assign value = value_r;
    assign valid = valid_r;
    assign busy  = busy_r;

endmodule
